// File: rtl/dmem_rom_arbiter.sv
// dmem_rom_arbiter: round-robin share of one combinational ROM read port between the load unit (port 0, stallable) and the image streamer (port 1), with registered data, range error and 1-cycle latency
module dmem_rom_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  output logic              stall0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd
);
  typedef enum logic {LAST0, LAST1} state_t;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
  state_t state, state_nx;
  logic in_range;
  always_comb begin
    gnt0 = req0 & (~req1 | (state == LAST1));
    gnt1 = req1 & ~gnt0;
    state_nx = gnt0 ? LAST0 : gnt1 ? LAST1 : state;
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    in_range = rom_addr < LIMIT;
  end
  assign stall0 = req0 & ~gnt0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LAST1;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0) begin
        rdata0 <= in_range ? rom_rd : '0;
        err0   <= ~in_range;
      end
      if (gnt1) begin
        rdata1 <= in_range ? rom_rd : '0;
        err1   <= ~in_range;
      end
    end
  end
endmodule

// File: tb/tb_dmem_rom_arbiter.sv
// tb_dmem_rom_arbiter: directed self-checking bench for dmem_rom_arbiter
module tb_dmem_rom_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, stall0;
  logic [31:0] rdata0, rdata1, rom_addr, rom_rd;
  int checks = 0, errors = 0;
  dmem_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0), .stall0(stall0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .rom_addr(rom_addr), .rom_rd(rom_rd)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a == 32'd5) ? 32'hDEADBEEF : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction
  assign rom_rd = rom_f(rom_addr);
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'd1; addr1 = 32'd2;
    step();
    checks++;
    if ({rvalid0, rvalid1, err0, err1, rdata0, rdata1} !== 68'd0) begin
      errors++; $display("FAIL reset_outputs: got rv=%b%b err=%b%b d0=%h d1=%h want all zero", rvalid0, rvalid1, err0, err1, rdata0, rdata1);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, stall0} !== 3'b100) begin
      errors++; $display("FAIL reset_first_grant: got gnt0/gnt1/stall0=%b%b%b want 100", gnt0, gnt1, stall0);
    end
    step();
    checks++;
    if ({rvalid0, rvalid1, err0, rdata0} !== {3'b100, rom_f(32'd1)}) begin
      errors++; $display("FAIL reset_read0: got rv=%b%b err0=%b d0=%h want 100 %h", rvalid0, rvalid1, err0, rdata0, rom_f(32'd1));
    end
    checks++;
    if ({gnt0, gnt1, stall0} !== 3'b011) begin
      errors++; $display("FAIL reset_second_grant: got gnt0/gnt1/stall0=%b%b%b want 011", gnt0, gnt1, stall0);
    end
    req0 = 1'b0;
    step();
    req1 = 1'b0;
    checks++;
    if ({rvalid0, rvalid1, err1, rdata1} !== {3'b010, rom_f(32'd2)}) begin
      errors++; $display("FAIL reset_read1: got rv=%b%b err1=%b d1=%h want 010 %h", rvalid0, rvalid1, err1, rdata1, rom_f(32'd2));
    end
    step();
  endtask
  task automatic test_single;
    req0 = 1'b1; addr0 = 32'd5;
    #1;
    checks++;
    if ({gnt0, gnt1, stall0, rom_addr} !== {3'b100, 32'd5}) begin
      errors++; $display("FAIL single_grant: got gnt/stall=%b%b%b rom_addr=%0d want 100 5", gnt0, gnt1, stall0, rom_addr);
    end
    step();
    req0 = 1'b0;
    checks++;
    if ({rvalid0, rvalid1, err0, rdata0} !== {3'b100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_data: got rv=%b%b err0=%b d0=%h want 100 deadbeef", rvalid0, rvalid1, err0, rdata0);
    end
    step();
    checks++;
    if ({rvalid0, rdata0, rom_addr} !== {1'b0, 32'hDEADBEEF, 32'd0}) begin
      errors++; $display("FAIL single_hold: got rv0=%b d0=%h rom_addr=%h want 0 deadbeef 0", rvalid0, rdata0, rom_addr);
    end
  endtask
  task automatic test_bounds;
    logic [31:0] addrs [3] = '{32'd8099, 32'd8100, 32'hFFFFFFFF};
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr1 = addrs[i];
      #1;
      checks++;
      if ({gnt0, gnt1, rom_addr} !== {2'b01, addrs[i]}) begin
        errors++; $display("FAIL bounds_grant[%0d]: got gnt=%b%b rom_addr=%h want 01 %h", i, gnt0, gnt1, rom_addr, addrs[i]);
      end
      step();
      checks++;
      if ({rvalid0, rvalid1, err1, rdata1} !== ((i == 0) ? {3'b010, rom_f(32'd8099)} : {3'b011, 32'd0})) begin
        errors++; $display("FAIL bounds_data[%0d]: got rv=%b%b err1=%b d1=%h for addr %h", i, rvalid0, rvalid1, err1, rdata1, addrs[i]);
      end
    end
    req1 = 1'b0;
    step();
  endtask
  task automatic test_contention;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr0 = 32'd16 + 32'(i); addr1 = 32'd32 + 32'(i);
      #1;
      checks++;
      if ({gnt0, gnt1, stall0} !== ((i % 2 == 0) ? 3'b100 : 3'b011)) begin
        errors++; $display("FAIL contention_grant[%0d]: got gnt0/gnt1/stall0=%b%b%b", i, gnt0, gnt1, stall0);
      end
      step();
      checks++;
      if (i % 2 == 0 ? ({rvalid0, rvalid1, rdata0} !== {2'b10, rom_f(32'd16 + 32'(i))})
                     : ({rvalid0, rvalid1, rdata1} !== {2'b01, rom_f(32'd32 + 32'(i))})) begin
        errors++; $display("FAIL contention_data[%0d]: got rv=%b%b d0=%h d1=%h", i, rvalid0, rvalid1, rdata0, rdata1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask
  task automatic test_streaming;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr1 = 32'(i);
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        errors++; $display("FAIL stream_grant[%0d]: got gnt=%b%b want 01", i, gnt0, gnt1);
      end
      step();
      checks++;
      if ({rvalid1, err1, rdata1} !== {2'b10, rom_f(32'(i))}) begin
        errors++; $display("FAIL stream_data[%0d]: got rv1=%b err1=%b d1=%h want 10 %h", i, rvalid1, err1, rdata1, rom_f(32'(i)));
      end
    end
    req1 = 1'b0;
    step();
  endtask
  task automatic test_reset_midop;
    req0 = 1'b1; addr0 = 32'd6;
    step();
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, rom_f(32'd6)}) begin
      errors++; $display("FAIL midop_pre: got rv0=%b d0=%h want 1 %h", rvalid0, rdata0, rom_f(32'd6));
    end
    addr0 = 32'd7;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL midop_gnt: got gnt0=%b want 1", gnt0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid0, rdata0} !== 33'd0) begin
      errors++; $display("FAIL midop_async: got rv0=%b d0=%h want 0 0", rvalid0, rdata0);
    end
    step();
    req1 = 1'b1; addr1 = 32'd9;
    checks++;
    if ({rvalid0, rvalid1, rdata0} !== 34'd0) begin
      errors++; $display("FAIL midop_no_rvalid: got rv=%b%b d0=%h want 00 0", rvalid0, rvalid1, rdata0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL midop_first_grant: got gnt=%b%b want 10", gnt0, gnt1);
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if ({rvalid0, err0, rdata0} !== {2'b10, rom_f(32'd7)}) begin
      errors++; $display("FAIL midop_after: got rv0=%b err0=%b d0=%h want 10 %h", rvalid0, err0, rdata0, rom_f(32'd7));
    end
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_bounds();
    test_contention();
    test_streaming();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
